p04_count_tick_gen: RTL
=======================

Name: p04_count_tick_gen

Overview:
- Upstream stage for the p04 decade-counter/7-segment datapath.
- Turns raw board inputs into clean single-cycle control strobes: a free-running prescaled tick, a debounced manual step, and a debounced clear.
- count_en drives the counter's advance gate; clear_pulse drives its synchronous clear.
- No combinational path exists from any input to any output.

Parameters:
- DIV, 10000000, prescaler period in clk cycles between free-run ticks (>=2).
- DIV_W, 24, prescaler counter width; must satisfy 2**DIV_W >= DIV.
- DB_CYCLES, 50000, consecutive stable synchronized samples required to accept a button level change (>=2).
- DB_W, 16, debounce counter width; must satisfy 2**DB_W >= DB_CYCLES.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  tile enable; 0 freezes all state except the synchronizers.
- run  input  1  1 = free-run, prescaled ticks enabled; already synchronous.
- step_btn  input  1  raw asynchronous step pushbutton, active-high.
- clear_btn  input  1  raw asynchronous clear pushbutton, active-high.
- count_en  output  1  one-cycle advance strobe to the counter.
- clear_pulse  output  1  one-cycle clear strobe to the counter.
- step_level  output  1  debounced step-button level, for status display.
- tick_phase  output  DIV_W  current prescaler value, for debug.

Behaviour:
- Reset (async assert, sync release):
  - all flops are 0: synchronizers, debounced levels, debounce counters, prescaler, output registers.
  - count_en=0, clear_pulse=0, step_level=0, tick_phase=0.
- Synchronizers: two flops per button; they sample every cycle regardless of ena. s_step and s_clr are the second-stage outputs.
- Debouncer, one instance per button, state (level, cnt), updated only when ena=1:
  - s == level: cnt <= 0.
  - s != level and cnt == DB_CYCLES-1: level <= s, cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - A glitch shorter than DB_CYCLES synchronized cycles never changes level.
- Edge detect: step_edge = level_step & ~prev_step; clr_edge likewise. prev_* is registered under ena.
- Prescaler (pcnt, exposed on tick_phase), updated only when ena=1:
  - run=0: pcnt <= 0.
  - clr_edge=1: pcnt <= 0, regardless of run.
  - run=1 and pcnt == DIV-1: pcnt <= 0, tick=1.
  - otherwise: pcnt <= pcnt+1.
- Output registers, updated every cycle:
  - clear_pulse <= ena & clr_edge.
  - count_en <= ena & ~clr_edge & (tick | step_edge).
- Priority and simultaneity:
  - clear beats step and tick in the same cycle: count_en=0, clear_pulse=1.
  - tick and step_edge together produce one count_en pulse, never two.
- Latency:
  - A step press sampled high at edge 0 and held gives count_en high for exactly one cycle after edge DB_CYCLES+2.
  - Free-run: first count_en comes DIV edges after the edge that samples run=1, then every DIV cycles.
- ena=0: no strobes are produced; debouncers, edge history and prescaler hold their values; an edge pending before freeze is delivered after ena returns.
- Button held through reset release: level starts at 0, so the press is accepted DB_CYCLES+2 edges after release and yields one count_en.
- Reset asserted mid-debounce or mid-prescale: all progress is discarded, with no strobe on or after release unless the inputs warrant one.
- step_level mirrors the debounced step level directly.

Test Plan (DIV=4, DB_CYCLES=3):
- Reset, then run=1, ena=1, buttons low for 20 cycles -> count_en pulses one cycle wide at edges 4, 8, 12, 16, 20 after run; tick_phase cycles 1,2,3,0; clear_pulse stays 0.
- run=0, step_btn high at edge 0, held 10 cycles -> single count_en after edge 5; step_level=1 from edge 4; no further pulses while held; release gives no pulse.
- run=0, step_btn high for 2 cycles, then low -> step_level stays 0 and count_en never asserts (glitch rejected).
- run=1, clear_btn debounced so clr_edge coincides with pcnt==3 -> clear_pulse=1 and count_en=0 that cycle; tick_phase=0 next; next count_en 4 edges later.
- Step edge forced to coincide with a tick -> exactly one count_en cycle.
- ena=0 for 6 cycles mid-prescale with run=1 -> tick_phase frozen and no strobes; after ena=1 the period resumes from the held value. Separately, assert rst mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/p04_count_tick_gen_if.sv
// Control/status bundle between board-input conditioning and the p04 counter.
// The master side drives raw controls; the slave side (tick generator)
// returns the strobes and debug status.
interface p04_count_tick_gen_if #(
  parameter int DIV_W = 24
);
  logic             ena;
  logic             run;
  logic             step_btn;
  logic             clear_btn;
  logic             count_en;
  logic             clear_pulse;
  logic             step_level;
  logic [DIV_W-1:0] tick_phase;

  modport master (
    output ena, run, step_btn, clear_btn,
    input  count_en, clear_pulse, step_level, tick_phase
  );

  modport slave (
    input  ena, run, step_btn, clear_btn,
    output count_en, clear_pulse, step_level, tick_phase
  );
endinterface

// File: rtl/p04_count_tick_gen.sv
// p04 tick generator: synchronizes and debounces the step/clear buttons,
// runs the free-run prescaler, and emits registered one-cycle strobes.
// Lane 0 = step button, lane 1 = clear button.

// Per-button debouncer: level follows s only after DB_CYCLES consecutive
// enabled samples that disagree with the current level.
module p04_debounce #(
  parameter int DB_CYCLES = 50000,
  parameter int DB_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic s,
  output logic level
);
  logic [DB_W-1:0] cnt;

  // Stability counter; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (ena) begin
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module p04_count_tick_gen #(
  parameter int DIV       = 10000000,
  parameter int DIV_W     = 24,
  parameter int DB_CYCLES = 50000,
  parameter int DB_W      = 16
) (
  input logic            clk,
  input logic            rst,
  p04_count_tick_gen_if.slave bus
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0] btn, sync1, sync2, level, prev, edg;
  logic [DIV_W-1:0]     pcnt;
  logic                 clr_edge, step_edge, tick;
  logic                 count_en_q, clear_pulse_q;

  assign btn = {bus.clear_btn, bus.step_btn};

  // Two-flop synchronizers; they keep sampling even while the tile is frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  p04_debounce #(
    .DB_CYCLES(DB_CYCLES),
    .DB_W     (DB_W)
  ) u_db [NUM_LANES-1:0] (
    .clk  (clk),
    .rst  (rst),
    .ena  (bus.ena),
    .s    (sync2),
    .level(level)
  );

  // Edge history only advances when enabled, so a rising level seen just
  // before a freeze is still delivered once ena returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else if (bus.ena) prev <= level;
  end

  assign edg       = level & ~prev;
  assign step_edge = edg[0];
  assign clr_edge  = edg[1];
  // Clear restarts the period, so a wrap coinciding with it is not a tick.
  assign tick      = bus.run & (pcnt == DIV_W'(DIV - 1)) & ~clr_edge;

  // Prescaler: held at zero while stopped, restarted by a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (bus.ena) begin
      if (!bus.run || clr_edge)          pcnt <= '0;
      else if (pcnt == DIV_W'(DIV - 1))  pcnt <= '0;
      else                               pcnt <= pcnt + 1'b1;
    end
  end

  // Registered strobes; clear wins, and tick+step merge into one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_en_q    <= 1'b0;
      clear_pulse_q <= 1'b0;
    end else begin
      clear_pulse_q <= bus.ena & clr_edge;
      count_en_q    <= bus.ena & ~clr_edge & (tick | step_edge);
    end
  end

  assign bus.count_en    = count_en_q;
  assign bus.clear_pulse = clear_pulse_q;
  assign bus.step_level  = level[0];
  assign bus.tick_phase  = pcnt;
endmodule
